ctrlport_req_arbiter: RTL and testbench

//   Shares one CTRL Port master interface between NUM_PORTS requesting CTRL Port slave interfaces.
//   - Captures each requester's one-cycle request pulse, grants round-robin, keeps one transaction

---
 rtl/ctrlport_pkg.sv | 18 +
 rtl/ctrlport_req_slot.sv | 47 ++++
 rtl/ctrlport_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ctrlport_req_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrlport_pkg.sv
// Shared CTRL Port field widths and response status codes.
// Used by every block that speaks CTRL Port.
package ctrlport_pkg;

  localparam int CTRLPORT_ADDR_W     = 20;
  localparam int CTRLPORT_PORTID_W   = 10;
  localparam int CTRLPORT_REM_EPID_W = 16;
  localparam int CTRLPORT_DATA_W     = 32;
  localparam int CTRLPORT_BYTE_EN_W  = 4;
  localparam int CTRLPORT_TIME_W     = 64;
  localparam int CTRLPORT_STS_W      = 2;

  localparam logic [CTRLPORT_STS_W-1:0] CTRLPORT_STS_OKAY    = 2'b00;
  localparam logic [CTRLPORT_STS_W-1:0] CTRLPORT_STS_CMDERR  = 2'b01;
  localparam logic [CTRLPORT_STS_W-1:0] CTRLPORT_STS_TSERR   = 2'b10;
  localparam logic [CTRLPORT_STS_W-1:0] CTRLPORT_STS_WARNING = 2'b11;

endpackage

// File: rtl/ctrlport_req_slot.sv
// One requester's capture slot: holds a request from capture until its response
// is returned; a request arriving while the slot is occupied is dropped and flagged.
module ctrlport_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [W-1:0] req_data,
  input  logic         take,
  input  logic         clear,
  output logic         pending,
  output logic [W-1:0] data,
  output logic         overrun
);

  // Occupied covers both waiting-for-grant and in-flight.
  logic occupied;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      // NOTE: the capture register is reset as well so no X can reach the shared bus.
      data     <= '0;
    end else begin
      overrun <= 1'b0;
      if (clear) begin
        occupied <= 1'b0;
        pending  <= 1'b0;
      end else if (take) begin
        pending <= 1'b0;
      end
      if (req) begin
        if (!occupied) begin
          occupied <= 1'b1;
          pending  <= 1'b1;
          data     <= req_data;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ctrlport_req_arbiter.sv
// Round-robin arbiter sharing one CTRL Port master between NUM_PORTS requesters,
// with one downstream transaction outstanding and an optional response timeout.
module ctrlport_req_arbiter
  import ctrlport_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                                      ctrlport_clk,
  input  logic                                      ctrlport_rst,
  input  logic [NUM_PORTS-1:0]                      s_ctrlport_req_wr,
  input  logic [NUM_PORTS-1:0]                      s_ctrlport_req_rd,
  input  logic [NUM_PORTS*CTRLPORT_ADDR_W-1:0]      s_ctrlport_req_addr,
  input  logic [NUM_PORTS*CTRLPORT_PORTID_W-1:0]    s_ctrlport_req_portid,
  input  logic [NUM_PORTS*CTRLPORT_REM_EPID_W-1:0]  s_ctrlport_req_rem_epid,
  input  logic [NUM_PORTS*CTRLPORT_PORTID_W-1:0]    s_ctrlport_req_rem_portid,
  input  logic [NUM_PORTS*CTRLPORT_DATA_W-1:0]      s_ctrlport_req_data,
  input  logic [NUM_PORTS*CTRLPORT_BYTE_EN_W-1:0]   s_ctrlport_req_byte_en,
  input  logic [NUM_PORTS-1:0]                      s_ctrlport_req_has_time,
  input  logic [NUM_PORTS*CTRLPORT_TIME_W-1:0]      s_ctrlport_req_time,
  output logic [NUM_PORTS-1:0]                      s_ctrlport_resp_ack,
  output logic [NUM_PORTS*CTRLPORT_STS_W-1:0]       s_ctrlport_resp_status,
  output logic [NUM_PORTS*CTRLPORT_DATA_W-1:0]      s_ctrlport_resp_data,
  output logic                                      m_ctrlport_req_wr,
  output logic                                      m_ctrlport_req_rd,
  output logic [CTRLPORT_ADDR_W-1:0]                m_ctrlport_req_addr,
  output logic [CTRLPORT_PORTID_W-1:0]              m_ctrlport_req_portid,
  output logic [CTRLPORT_REM_EPID_W-1:0]            m_ctrlport_req_rem_epid,
  output logic [CTRLPORT_PORTID_W-1:0]              m_ctrlport_req_rem_portid,
  output logic [CTRLPORT_DATA_W-1:0]                m_ctrlport_req_data,
  output logic [CTRLPORT_BYTE_EN_W-1:0]             m_ctrlport_req_byte_en,
  output logic                                      m_ctrlport_req_has_time,
  output logic [CTRLPORT_TIME_W-1:0]                m_ctrlport_req_time,
  input  logic                                      m_ctrlport_resp_ack,
  input  logic [CTRLPORT_STS_W-1:0]                 m_ctrlport_resp_status,
  input  logic [CTRLPORT_DATA_W-1:0]                m_ctrlport_resp_data,
  output logic [NUM_PORTS-1:0]                      err_overrun
);

  localparam int GW    = $clog2(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW:0]      NP      = (GW + 1)'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [CTRLPORT_ADDR_W-1:0]     addr;
    logic [CTRLPORT_PORTID_W-1:0]   portid;
    logic [CTRLPORT_REM_EPID_W-1:0] rem_epid;
    logic [CTRLPORT_PORTID_W-1:0]   rem_portid;
    logic [CTRLPORT_DATA_W-1:0]     data;
    logic [CTRLPORT_BYTE_EN_W-1:0]  byte_en;
    logic                           has_time;
    logic [CTRLPORT_TIME_W-1:0]     tstamp;
  } fields_t;

  typedef struct packed {
    logic    wr;
    logic    rd;
    fields_t f;
  } req_t;

  state_t               state;
  logic [GW-1:0]        last_grant;  // also the owner of the outstanding transaction
  logic [CNT_W-1:0]     cnt;
  fields_t              m_f;
  req_t                 slot_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] pending, take, clear, grant_oh;
  logic [GW-1:0]        winner;
  logic                 found, timeout, resp_done;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    req_t req_in;
    assign req_in = {s_ctrlport_req_wr[p], s_ctrlport_req_rd[p],
                     s_ctrlport_req_addr[p*CTRLPORT_ADDR_W +: CTRLPORT_ADDR_W],
                     s_ctrlport_req_portid[p*CTRLPORT_PORTID_W +: CTRLPORT_PORTID_W],
                     s_ctrlport_req_rem_epid[p*CTRLPORT_REM_EPID_W +: CTRLPORT_REM_EPID_W],
                     s_ctrlport_req_rem_portid[p*CTRLPORT_PORTID_W +: CTRLPORT_PORTID_W],
                     s_ctrlport_req_data[p*CTRLPORT_DATA_W +: CTRLPORT_DATA_W],
                     s_ctrlport_req_byte_en[p*CTRLPORT_BYTE_EN_W +: CTRLPORT_BYTE_EN_W],
                     s_ctrlport_req_has_time[p],
                     s_ctrlport_req_time[p*CTRLPORT_TIME_W +: CTRLPORT_TIME_W]};

    ctrlport_req_slot #(.W($bits(req_t))) u_slot (
      .clk      (ctrlport_clk),
      .rst      (ctrlport_rst),
      .req      (s_ctrlport_req_wr[p] | s_ctrlport_req_rd[p]),
      .req_data (req_in),
      .take     (take[p]),
      .clear    (clear[p]),
      .pending  (pending[p]),
      .data     (slot_q[p]),
      .overrun  (err_overrun[p])
    );
  end

  // Round-robin: first pending port after the last grant, wrapping.
  always_comb begin
    logic [GW:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = last_grant;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = {1'b0, last_grant} + (GW + 1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (!found && pending[idx[GW-1:0]]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    take     = '0;
    grant_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      grant_oh[p] = (last_grant == GW'(p));
      take[p]     = (state == IDLE) && found && (winner == GW'(p));
    end
  end

  assign timeout   = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign resp_done = (state == WAIT) && (m_ctrlport_resp_ack || timeout);
  assign clear     = resp_done ? grant_oh : '0;

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      state                  <= IDLE;
      last_grant             <= GW'(NUM_PORTS - 1);
      cnt                    <= '0;
      m_ctrlport_req_wr      <= 1'b0;
      m_ctrlport_req_rd      <= 1'b0;
      m_f                    <= '0;
      s_ctrlport_resp_ack    <= '0;
      s_ctrlport_resp_status <= '0;
      s_ctrlport_resp_data   <= '0;
    end else begin
      // NOTE: default-low assignments make every strobe a one-cycle pulse and
      // keep response status/data at zero outside the ack cycle.
      m_ctrlport_req_wr      <= 1'b0;
      m_ctrlport_req_rd      <= 1'b0;
      s_ctrlport_resp_ack    <= '0;
      s_ctrlport_resp_status <= '0;
      s_ctrlport_resp_data   <= '0;
      case (state)
        IDLE: if (found) begin
          last_grant        <= winner;
          m_ctrlport_req_wr <= slot_q[winner].wr;
          m_ctrlport_req_rd <= slot_q[winner].rd;
          m_f               <= slot_q[winner].f;
          state             <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (resp_done) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (grant_oh[p]) begin
                s_ctrlport_resp_ack[p] <= 1'b1;
                s_ctrlport_resp_status[p*CTRLPORT_STS_W +: CTRLPORT_STS_W] <=
                  m_ctrlport_resp_ack ? m_ctrlport_resp_status : CTRLPORT_STS_CMDERR;
                s_ctrlport_resp_data[p*CTRLPORT_DATA_W +: CTRLPORT_DATA_W] <=
                  m_ctrlport_resp_ack ? m_ctrlport_resp_data : '0;
              end
            end
            state <= IDLE;
          end else if (~&cnt) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_ctrlport_req_addr       = m_f.addr;
  assign m_ctrlport_req_portid     = m_f.portid;
  assign m_ctrlport_req_rem_epid   = m_f.rem_epid;
  assign m_ctrlport_req_rem_portid = m_f.rem_portid;
  assign m_ctrlport_req_data       = m_f.data;
  assign m_ctrlport_req_byte_en    = m_f.byte_en;
  assign m_ctrlport_req_has_time   = m_f.has_time;
  assign m_ctrlport_req_time       = m_f.tstamp;

endmodule

// File: tb/tb_ctrlport_req_arbiter.sv
// Scoreboard bench for ctrlport_req_arbiter: directed requests push expected
// downstream requests, responses and overrun pulses; a monitor pops and compares.
module tb_ctrlport_req_arbiter;
  import ctrlport_pkg::*;

  localparam int NP   = 4;
  localparam int TO   = 8;
  localparam int MB_W = 2 + CTRLPORT_ADDR_W + 2*CTRLPORT_PORTID_W + CTRLPORT_REM_EPID_W
                      + CTRLPORT_DATA_W + CTRLPORT_BYTE_EN_W + 1 + CTRLPORT_TIME_W;
  localparam int SB_W = NP + NP*CTRLPORT_STS_W + NP*CTRLPORT_DATA_W;

  typedef struct { logic [255:0] v; int at; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]                     s_wr, s_rd, s_ht, s_ack, ovr;
  logic [NP*CTRLPORT_ADDR_W-1:0]     s_addr;
  logic [NP*CTRLPORT_PORTID_W-1:0]   s_pid, s_rpid;
  logic [NP*CTRLPORT_REM_EPID_W-1:0] s_epid;
  logic [NP*CTRLPORT_DATA_W-1:0]     s_dat, s_rdat;
  logic [NP*CTRLPORT_BYTE_EN_W-1:0]  s_be;
  logic [NP*CTRLPORT_TIME_W-1:0]     s_time;
  logic [NP*CTRLPORT_STS_W-1:0]      s_sts;
  logic                              m_wr, m_rd, m_ht, m_ack;
  logic [CTRLPORT_ADDR_W-1:0]        m_addr;
  logic [CTRLPORT_PORTID_W-1:0]      m_pid, m_rpid;
  logic [CTRLPORT_REM_EPID_W-1:0]    m_epid;
  logic [CTRLPORT_DATA_W-1:0]        m_dat, m_rdat;
  logic [CTRLPORT_BYTE_EN_W-1:0]     m_be;
  logic [CTRLPORT_TIME_W-1:0]        m_time;
  logic [CTRLPORT_STS_W-1:0]         m_sts;

  logic [MB_W-1:0] m_bus;
  logic [SB_W-1:0] s_bus;
  assign m_bus = {m_wr, m_rd, m_addr, m_pid, m_epid, m_rpid, m_dat, m_be, m_ht, m_time};
  assign s_bus = {s_ack, s_sts, s_rdat};

  exp_t exp_m[$], exp_s[$], exp_o[$];
  int compared = 0, mismatched = 0, cyc = 0;

  ctrlport_req_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .ctrlport_clk              (clk),
    .ctrlport_rst              (rst),
    .s_ctrlport_req_wr         (s_wr),
    .s_ctrlport_req_rd         (s_rd),
    .s_ctrlport_req_addr       (s_addr),
    .s_ctrlport_req_portid     (s_pid),
    .s_ctrlport_req_rem_epid   (s_epid),
    .s_ctrlport_req_rem_portid (s_rpid),
    .s_ctrlport_req_data       (s_dat),
    .s_ctrlport_req_byte_en    (s_be),
    .s_ctrlport_req_has_time   (s_ht),
    .s_ctrlport_req_time       (s_time),
    .s_ctrlport_resp_ack       (s_ack),
    .s_ctrlport_resp_status    (s_sts),
    .s_ctrlport_resp_data      (s_rdat),
    .m_ctrlport_req_wr         (m_wr),
    .m_ctrlport_req_rd         (m_rd),
    .m_ctrlport_req_addr       (m_addr),
    .m_ctrlport_req_portid     (m_pid),
    .m_ctrlport_req_rem_epid   (m_epid),
    .m_ctrlport_req_rem_portid (m_rpid),
    .m_ctrlport_req_data       (m_dat),
    .m_ctrlport_req_byte_en    (m_be),
    .m_ctrlport_req_has_time   (m_ht),
    .m_ctrlport_req_time       (m_time),
    .m_ctrlport_resp_ack       (m_ack),
    .m_ctrlport_resp_status    (m_sts),
    .m_ctrlport_resp_data      (m_rdat),
    .err_overrun               (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [255:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected output %h (cycle %0d)", name, act, cyc);
  endtask

  task automatic push(input int q, input logic [255:0] v, input int at);
    exp_t e;
    e.v  = v;
    e.at = at;
    case (q)
      0:       exp_m.push_back(e);
      1:       exp_s.push_back(e);
      default: exp_o.push_back(e);
    endcase
  endtask

  // Requester-side fields are derived from the port number so each port is distinct.
  function automatic logic [MB_W-1:0] mk_req(input int p, input logic wr, input logic rd,
                                             input logic [19:0] addr, input logic [31:0] data);
    logic [9:0]  pid   = 10'(p + 16);
    logic [15:0] epid  = 16'(16'hE000 + p);
    logic [9:0]  rpid  = 10'(3 * p + 1);
    logic [3:0]  be    = 4'(4'hF >> p);
    logic        ht    = p[0];
    logic [63:0] tstmp = 64'hC0DE_0000_0000_0000 + 64'(p);
    return {wr, rd, addr, pid, epid, rpid, data, be, ht, tstmp};
  endfunction

  function automatic logic [SB_W-1:0] mk_resp(input int p, input logic [1:0] st, input logic [31:0] d);
    logic [NP-1:0]   a  = '0;
    logic [2*NP-1:0] s  = '0;
    logic [32*NP-1:0] dd = '0;
    a[p]         = 1'b1;
    s[p*2 +: 2]  = st;
    dd[p*32 +: 32] = d;
    return {a, s, dd};
  endfunction

  task automatic drive(input int p, input logic [MB_W-1:0] b);
    {s_wr[p], s_rd[p], s_addr[p*20 +: 20], s_pid[p*10 +: 10], s_epid[p*16 +: 16],
     s_rpid[p*10 +: 10], s_dat[p*32 +: 32], s_be[p*4 +: 4], s_ht[p], s_time[p*64 +: 64]} = b;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_req();
    s_wr = '0;
    s_rd = '0;
  endtask

  task automatic wait_m();
    int n = 0;
    while (!(m_wr | m_rd)) begin
      if (n == 40) begin
        compared++;
        mismatched++;
        $display("FAIL wait_m: no m_req within 40 cycles (cycle %0d)", cyc);
        return;
      end
      tick(1);
      n++;
    end
  endtask

  task automatic ack_pulse(input logic [1:0] st, input logic [31:0] d);
    m_ack = 1'b1;
    m_sts = st;
    m_rdat = d;
    tick(1);
    m_ack = 1'b0;
    m_sts = '0;
    m_rdat = '0;
  endtask

  task automatic serve(input logic [1:0] st, input logic [31:0] d);
    wait_m();
    tick(1);
    ack_pulse(st, d);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_wr | m_rd) begin
          if (exp_m.size() == 0) unexpected("m_req", 256'(m_bus));
          else begin
            e = exp_m.pop_front();
            check("m_req fields", 256'(m_bus), e.v);
            if (e.at >= 0) check("m_req cycle", 256'(cyc), 256'(e.at));
          end
        end
        if (|s_ack) begin
          if (exp_s.size() == 0) unexpected("s_resp", 256'(s_bus));
          else begin
            e = exp_s.pop_front();
            check("s_resp bus", 256'(s_bus), e.v);
            if (e.at >= 0) check("s_resp cycle", 256'(cyc), 256'(e.at));
          end
        end else begin
          check("s_resp idle zero", 256'({s_sts, s_rdat}), 256'(0));
        end
        if (|ovr) begin
          if (exp_o.size() == 0) unexpected("err_overrun", 256'(ovr));
          else begin
            e = exp_o.pop_front();
            check("err_overrun vec", 256'(ovr), e.v);
            if (e.at >= 0) check("err_overrun cycle", 256'(cyc), 256'(e.at));
          end
        end
      end
    end
  end

  initial begin
    logic [MB_W-1:0] r0, r1, r3, r;
    int n;
    rst = 1'b1;
    s_wr = '0; s_rd = '0; s_addr = '0; s_pid = '0; s_epid = '0; s_rpid = '0;
    s_dat = '0; s_be = '0; s_ht = '0; s_time = '0;
    m_ack = 1'b0; m_sts = '0; m_rdat = '0;
    tick(3);
    check("reset outputs", 256'({m_bus, s_bus, ovr}), 256'(0));
    rst = 1'b0;
    tick(2);

    // Three ports at once, twice: round-robin order 0,1,3 both times.
    for (int rep = 0; rep < 2; rep++) begin
      n  = cyc;
      r0 = mk_req(0, 1'b1, 1'b0, 20'(20'h100 + rep), 32'h0000_0A00 + 32'(rep));
      r1 = mk_req(1, 1'b1, 1'b1, 20'(20'h200 + rep), 32'h0000_0B00 + 32'(rep));
      r3 = mk_req(3, 1'b0, 1'b1, 20'(20'h300 + rep), 32'h0000_0D00 + 32'(rep));
      drive(3, r3);
      drive(0, r0);
      drive(1, r1);
      push(0, 256'(r0), (rep == 0) ? n + 2 : -1);
      push(0, 256'(r1), -1);
      push(0, 256'(r3), -1);
      push(1, 256'(mk_resp(0, CTRLPORT_STS_OKAY, 32'h0A0A_0A0A)), -1);
      push(1, 256'(mk_resp(1, CTRLPORT_STS_WARNING, 32'h1111_2222)), -1);
      push(1, 256'(mk_resp(3, CTRLPORT_STS_TSERR, 32'h3030_3030)), -1);
      tick(1);
      release_req();
      serve(CTRLPORT_STS_OKAY, 32'h0A0A_0A0A);
      serve(CTRLPORT_STS_WARNING, 32'h1111_2222);
      serve(CTRLPORT_STS_TSERR, 32'h3030_3030);
    end
    tick(2);

    // Single write on port 2: m_req 2 cycles later, s ack 1 cycle after m ack.
    n = cyc;
    r = mk_req(2, 1'b1, 1'b0, 20'h00040, 32'hDEAD_BEEF);
    drive(2, r);
    push(0, 256'(r), n + 2);
    push(1, 256'(mk_resp(2, CTRLPORT_STS_OKAY, 32'h0)), n + 4);
    tick(1);
    release_req();
    serve(CTRLPORT_STS_OKAY, 32'h0);
    tick(2);

    // Read on port 1: data routed only to port 1.
    n = cyc;
    r = mk_req(1, 1'b0, 1'b1, 20'h00084, 32'h0);
    drive(1, r);
    push(0, 256'(r), n + 2);
    push(1, 256'(mk_resp(1, CTRLPORT_STS_OKAY, 32'h1234_5678)), n + 4);
    tick(1);
    release_req();
    serve(CTRLPORT_STS_OKAY, 32'h1234_5678);
    tick(2);

    // Second request on port 0 while its first is in flight: dropped with overrun.
    n = cyc;
    r = mk_req(0, 1'b1, 1'b0, 20'h00500, 32'h5555_0001);
    drive(0, r);
    push(0, 256'(r), n + 2);
    push(2, 256'(4'b0001), n + 4);
    push(1, 256'(mk_resp(0, CTRLPORT_STS_OKAY, 32'h0000_0005)), n + 5);
    tick(1);
    release_req();
    wait_m();
    tick(1);
    drive(0, mk_req(0, 1'b1, 1'b0, 20'h00501, 32'h5555_0002));
    tick(1);
    release_req();
    ack_pulse(CTRLPORT_STS_OKAY, 32'h0000_0005);
    tick(8);

    // No ack: timeout response 9 cycles after ISSUE; a late ack is ignored.
    n = cyc;
    r = mk_req(3, 1'b1, 1'b0, 20'h00700, 32'h7777_0007);
    drive(3, r);
    push(0, 256'(r), n + 2);
    push(1, 256'(mk_resp(3, CTRLPORT_STS_CMDERR, 32'h0)), n + 11);
    tick(1);
    release_req();
    wait_m();
    tick(10);
    ack_pulse(CTRLPORT_STS_OKAY, 32'hBAD0_BAD0);
    tick(5);

    // Reset during WAIT: outputs clear at once, post-reset ack ignored, then normal operation.
    r = mk_req(2, 1'b0, 1'b1, 20'h00900, 32'h0);
    drive(2, r);
    push(0, 256'(r), cyc + 2);
    tick(1);
    release_req();
    wait_m();
    tick(2);
    rst = 1'b1;
    #1;
    check("reset in WAIT", 256'({m_bus, s_bus, ovr}), 256'(0));
    tick(1);
    rst = 1'b0;
    tick(1);
    ack_pulse(CTRLPORT_STS_OKAY, 32'h0000_0077);
    tick(3);
    n = cyc;
    r = mk_req(2, 1'b1, 1'b0, 20'h00A00, 32'hA5A5_5A5A);
    drive(2, r);
    push(0, 256'(r), n + 2);
    push(1, 256'(mk_resp(2, CTRLPORT_STS_OKAY, 32'h2468_ACE0)), n + 4);
    tick(1);
    release_req();
    serve(CTRLPORT_STS_OKAY, 32'h2468_ACE0);
    tick(10);

    check("m queue drained", 256'(exp_m.size()), 256'(0));
    check("s queue drained", 256'(exp_s.size()), 256'(0));
    check("overrun queue drained", 256'(exp_o.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
